// File: rtl/mem_access_unit_pkg.sv
// Shared word width, data memory size and access-size encodings for mem_access_unit.
package mem_access_unit_pkg;

  localparam int unsigned WORD_LEN      = 32;
  localparam int unsigned DATA_MEM_SIZE = 1024;

  localparam logic [1:0] MEM_SZ_BYTE = 2'b00;
  localparam logic [1:0] MEM_SZ_HALF = 2'b01;
  localparam logic [1:0] MEM_SZ_WORD = 2'b10;

  // Offset of the last byte touched by an access of the given size.
  function automatic logic [2:0] size_last(input logic [1:0] size);
    case (size)
      MEM_SZ_BYTE: size_last = 3'd0;
      MEM_SZ_HALF: size_last = 3'd1;
      default:     size_last = 3'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Big-endian lane extract/extend for loads and lane merge for sub-word stores.
module mem_lane_merge
  import mem_access_unit_pkg::*;
(
  input  logic [WORD_LEN-1:0] rd_word,
  input  logic [WORD_LEN-1:0] wr_data,
  input  logic [1:0]          offset,
  input  logic [1:0]          size,
  input  logic                is_unsigned,
  output logic [WORD_LEN-1:0] load_data_c,
  output logic [WORD_LEN-1:0] merge_data_c
);

  logic [4:0]          shamt;
  logic [WORD_LEN-1:0] lane_mask;
  logic [WORD_LEN-1:0] shifted;

  // Byte k sits at bits [31-8k -: 8]; 3-k is simply ~k for a 2-bit offset.
  always_comb begin
    shamt        = '0;
    lane_mask    = '1;
    shifted      = rd_word;
    load_data_c  = rd_word;
    merge_data_c = wr_data;
    case (size)
      MEM_SZ_BYTE: begin
        shamt        = {~offset, 3'b000};
        lane_mask    = WORD_LEN'(8'hFF) << shamt;
        shifted      = rd_word >> shamt;
        load_data_c  = is_unsigned ? WORD_LEN'(shifted[7:0])
                                   : {{(WORD_LEN-8){shifted[7]}}, shifted[7:0]};
        merge_data_c = (rd_word & ~lane_mask) | (WORD_LEN'(wr_data[7:0]) << shamt);
      end
      MEM_SZ_HALF: begin
        shamt        = {~offset[1], 4'b0000};
        lane_mask    = WORD_LEN'(16'hFFFF) << shamt;
        shifted      = rd_word >> shamt;
        load_data_c  = is_unsigned ? WORD_LEN'(shifted[15:0])
                                   : {{(WORD_LEN-16){shifted[15]}}, shifted[15:0]};
        merge_data_c = (rd_word & ~lane_mask) | (WORD_LEN'(wr_data[15:0]) << shamt);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the big-endian data memory; sub-word accesses
// (read-modify-write stores, extended loads) exist only with MEM_ACCESS_SUBWORD_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned MEM_BYTES = DATA_MEM_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [WORD_LEN-1:0] req_addr,
  input  logic [WORD_LEN-1:0] req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WORD_LEN-1:0] rsp_rdata,
  output logic                rsp_err,
  output logic                mem_readEn,
  output logic                mem_writeEn,
  output logic [WORD_LEN-1:0] mem_address,
  output logic [WORD_LEN-1:0] mem_dataIn,
  input  logic [WORD_LEN-1:0] mem_dataOut
);

  localparam int unsigned AW = WORD_LEN + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic [WORD_LEN-3:0] waddr_q, waddr_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [WORD_LEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                rd_en_q, rd_en_d;
  logic                wr_en_q, wr_en_d;
  logic [WORD_LEN-1:0] addr_q, addr_d;
  logic [WORD_LEN-1:0] wdat_q, wdat_d;
  logic [AW-1:0]       last_c;
  logic                acc_err_c;

`ifdef MEM_ACCESS_SUBWORD_EN
  logic [WORD_LEN-1:0] wdata_q, wdata_d;
  logic [1:0]          off_q, off_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [WORD_LEN-1:0] load_data_c;
  logic [WORD_LEN-1:0] merge_data_c;

  mem_lane_merge u_merge (
    .rd_word      (mem_dataOut),
    .wr_data      (wdata_q),
    .offset       (off_q),
    .size         (size_q),
    .is_unsigned  (uns_q),
    .load_data_c  (load_data_c),
    .merge_data_c (merge_data_c)
  );
`else
  logic cfg_unused;
  assign cfg_unused = req_unsigned;
`endif

  // Alignment, size and range check on the incoming request.
  always_comb begin
    acc_err_c = 1'b0;
    last_c    = {1'b0, req_addr} + AW'(size_last(req_size));
    case (req_size)
      MEM_SZ_BYTE: ;
      MEM_SZ_HALF: acc_err_c = req_addr[0];
      MEM_SZ_WORD: acc_err_c = (req_addr[1:0] != 2'b00);
      default:     acc_err_c = 1'b1;
    endcase
    if (last_c >= AW'(MEM_BYTES)) acc_err_c = 1'b1;
`ifndef MEM_ACCESS_SUBWORD_EN
    if (req_size != MEM_SZ_WORD) acc_err_c = 1'b1;
`endif
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    waddr_d     = waddr_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    wdat_d      = '0;
`ifdef MEM_ACCESS_SUBWORD_EN
    wdata_d     = wdata_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d     = req_write;
          waddr_d     = req_addr[WORD_LEN-1:2];
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
`ifdef MEM_ACCESS_SUBWORD_EN
          wdata_d     = req_wdata;
          off_d       = req_addr[1:0];
          size_d      = req_size;
          uns_d       = req_unsigned;
`endif
          if (acc_err_c) begin
            state_d   = S_RESP;
            rsp_err_d = 1'b1;
          end else if (req_write && req_size == MEM_SZ_WORD) begin
            state_d = S_WRITE;
            wdat_d  = req_wdata;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (write_q) begin
          state_d = S_WRITE;
`ifdef MEM_ACCESS_SUBWORD_EN
          wdat_d  = merge_data_c;
`endif
        end else begin
          state_d = S_RESP;
`ifdef MEM_ACCESS_SUBWORD_EN
          rsp_rdata_d = load_data_c;
`else
          rsp_rdata_d = mem_dataOut;
`endif
        end
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    rd_en_d     = (state_d == S_READ);
    wr_en_d     = (state_d == S_WRITE);
    addr_d      = (rd_en_d || wr_en_d) ? {waddr_d, 2'b00} : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      waddr_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      wdat_q      <= '0;
`ifdef MEM_ACCESS_SUBWORD_EN
      wdata_q     <= '0;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      waddr_q     <= waddr_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      wdat_q      <= wdat_d;
`ifdef MEM_ACCESS_SUBWORD_EN
      wdata_q     <= wdata_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
`endif
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign mem_readEn  = rd_en_q;
  assign mem_writeEn = wr_en_q;
  assign mem_address = addr_q;
  assign mem_dataIn  = wdat_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-array big-endian memory model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int unsigned MB = DATA_MEM_SIZE;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, mem_readEn, mem_writeEn;
  logic [31:0] rsp_rdata, mem_address, mem_dataIn, mem_dataOut;

  int checks = 0;
  int errors = 0;
  int ovl = 0;
  logic clr = 1'b1;
  logic [7:0] mem [MB];

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_readEn(mem_readEn),
    .mem_writeEn(mem_writeEn), .mem_address(mem_address), .mem_dataIn(mem_dataIn),
    .mem_dataOut(mem_dataOut)
  );

  always_comb begin
    mem_dataOut = '0;
    if (mem_address <= MB - 4)
      mem_dataOut = {mem[mem_address], mem[mem_address+1], mem[mem_address+2], mem[mem_address+3]};
  end

  // Memory writes on the falling edge inside the write cycle.
  always @(negedge clk) begin
    if (mem_writeEn && mem_readEn) ovl <= ovl + 1;
    if (clr) begin
      for (int i = 0; i < MB; i++) mem[i] <= 8'h00;
    end else if (mem_writeEn && mem_address <= MB - 4) begin
      mem[mem_address]   <= mem_dataIn[31:24];
      mem[mem_address+1] <= mem_dataIn[23:16];
      mem[mem_address+2] <= mem_dataIn[15:8];
      mem[mem_address+3] <= mem_dataIn[7:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int nrd, output int nwr);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0;
    do begin
      @(negedge clk);
      lat++;
      nrd += int'(mem_readEn);
      nwr += int'(mem_writeEn);
    end while (!rsp_valid && lat < 20);
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                     input logic [31:0] exp_rd, input logic exp_er, input int exp_nrd,
                     input int exp_nwr);
    int lat, nrd, nwr;
    logic [31:0] rd;
    logic er;
    do_req(w, sz, u, a, wd, lat, rd, er, nrd, nwr);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, 32'(er), 32'(exp_er));
    check({tag, "_rdpulse"}, 32'(nrd), 32'(exp_nrd));
    check({tag, "_wrpulse"}, 32'(nwr), 32'(exp_nwr));
  endtask

  logic [31:0] word10;
  int k;

  initial begin
    repeat (2) @(negedge clk);
    clr = 1'b0;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_flags", 32'({rsp_valid, rsp_err, mem_readEn, mem_writeEn}), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_addr", mem_address, 32'd0);
    check("rst_din", mem_dataIn, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_valid", 32'(rsp_valid), 32'd0);

    run("wst", 1'b1, MEM_SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0, 0, 1);
    check("mem_bytes", {mem[16], mem[17], mem[18], mem[19]}, 32'hDEADBEEF);
    run("wld", 1'b0, MEM_SZ_WORD, 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0, 1, 0);

    // Backpressure: response held, second request waits until after release.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = MEM_SZ_WORD; req_addr = 32'h10;
    k = 0;
    while (!rsp_valid && k < 20) begin @(negedge clk); k++; end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata", rsp_rdata, 32'hDEADBEEF);
      check("bp_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_rel_ready", 32'(req_ready), 32'd1);
    check("bp_rel_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("bp_accepted", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 20) begin @(negedge clk); k++; end
    check("bp2_rdata", rsp_rdata, 32'hDEADBEEF);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

`ifdef MEM_ACCESS_SUBWORD_EN
    run("bld_s", 1'b0, MEM_SZ_BYTE, 1'b0, 32'h13, 32'h0, 2, 32'hFFFFFFEF, 1'b0, 1, 0);
    run("bld_u", 1'b0, MEM_SZ_BYTE, 1'b1, 32'h13, 32'h0, 2, 32'h000000EF, 1'b0, 1, 0);
    run("hld_s", 1'b0, MEM_SZ_HALF, 1'b0, 32'h10, 32'h0, 2, 32'hFFFFDEAD, 1'b0, 1, 0);
    run("hld_u", 1'b0, MEM_SZ_HALF, 1'b1, 32'h12, 32'h0, 2, 32'h0000BEEF, 1'b0, 1, 0);
    run("bst", 1'b1, MEM_SZ_BYTE, 1'b0, 32'h11, 32'hAB55, 3, 32'h0, 1'b0, 1, 1);
    run("bst_rd", 1'b0, MEM_SZ_WORD, 1'b0, 32'h10, 32'h0, 2, 32'hDE55BEEF, 1'b0, 1, 0);
    run("hst", 1'b1, MEM_SZ_HALF, 1'b0, 32'h12, 32'hA5A51234, 3, 32'h0, 1'b0, 1, 1);
    word10 = 32'hDE551234;
`else
    run("bld_off", 1'b0, MEM_SZ_BYTE, 1'b0, 32'h13, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    run("hst_off", 1'b1, MEM_SZ_HALF, 1'b0, 32'h10, 32'h1111, 1, 32'h0, 1'b1, 0, 0);
    word10 = 32'hDEADBEEF;
`endif

    run("e_wld12", 1'b0, MEM_SZ_WORD, 1'b0, 32'h12, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    run("e_hst11", 1'b1, MEM_SZ_HALF, 1'b0, 32'h11, 32'h7777, 1, 32'h0, 1'b1, 0, 0);
    run("e_wrange", 1'b1, MEM_SZ_WORD, 1'b0, 32'(MB - 2), 32'h9999, 1, 32'h0, 1'b1, 0, 0);
    run("e_size3", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    run("e_wst_big", 1'b1, MEM_SZ_WORD, 1'b0, 32'(MB), 32'h1, 1, 32'h0, 1'b1, 0, 0);
    run("ok_top", 1'b0, MEM_SZ_WORD, 1'b0, 32'(MB - 4), 32'h0, 2, 32'h0, 1'b0, 1, 0);
    run("unchanged", 1'b0, MEM_SZ_WORD, 1'b0, 32'h10, 32'h0, 2, word10, 1'b0, 1, 0);

    // Reset asserted in the middle of the write cycle.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = MEM_SZ_WORD;
    req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("rstw_we_on", 32'(mem_writeEn), 32'd1);
    check("rstw_din", mem_dataIn, 32'h12345678);
    #1 rst = 1'b0;
    #1;
    check("rstw_we_off", 32'(mem_writeEn), 32'd0);
    check("rstw_flags", 32'({req_ready, rsp_valid, rsp_err, mem_readEn}), 32'd0);
    check("rstw_buses", mem_address | mem_dataIn | rsp_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstw_ready", 32'(req_ready), 32'd1);
    run("rstw_lost", 1'b0, MEM_SZ_WORD, 1'b0, 32'h20, 32'h0, 2, 32'h0, 1'b0, 1, 0);

    check("strobe_overlap", 32'(ovl), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that sits between the MEM pipeline stage and `MyMemory`, the byte-addressed big-endian data memory. Accepts one request at a time over a valid/ready handshake, drives the memory's `readEn`/`writeEn`/`address`/`dataIn`, and returns a response over a second valid/ready handshake. Supports byte/half/word loads with sign or zero extension. Sub-word stores are done by read-modify-write, because the memory only writes whole words.

## Interface
- `MEM_BYTES`, default `` `DATA_MEM_SIZE ``: addressable bytes. Any access whose byte range exceeds `MEM_BYTES-1` is an error.
- `clk` in 1: sole clock. Rising edge for all state.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle, so the request is accepted on this edge.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned` in 1: loads only. 1 = zero-extend, 0 = sign-extend.
- `req_addr` in `` `WORD_LEN ``: byte address.
- `req_wdata` in `` `WORD_LEN ``: store value, right-aligned.
- `rsp_valid` out 1: response present. Held until `rsp_ready`.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out `` `WORD_LEN ``: extended load result. 0 for stores and errors.
- `rsp_err` out 1: request was misaligned, out of range, reserved size, or an unsupported size.
- `mem_readEn`, `mem_writeEn` out 1: drive the memory's `readEn`/`writeEn`.
- `mem_address`, `mem_dataIn` out `` `WORD_LEN ``: drive the memory's `address`/`dataIn`.
- `mem_dataOut` in `` `WORD_LEN ``: memory's combinational read data.

## Operation
- **States:**
  - IDLE: `req_ready`=1.
  - READ: `mem_readEn`=1.
  - WRITE: `mem_writeEn`=1.
  - RESP: `rsp_valid`=1.
- **Accept:** a request is accepted when `req_valid && req_ready`. Address, size, data and flags are captured into registers.
- **Error check at accept:** the request is an error if any of these hold:
  - half with `addr[0]`≠0;
  - word with `addr[1:0]`≠0;
  - size 11;
  - `addr + bytes - 1 >= MEM_BYTES`.
  
  On error: IDLE→RESP with `rsp_err`=1 and `rsp_rdata`=0. No memory strobe is ever asserted.
- **Transitions:**
  - Load: IDLE→READ→RESP.
  - Word store: IDLE→WRITE→RESP.
  - Sub-word store: IDLE→READ→WRITE→RESP.
  - RESP→IDLE when `rsp_ready`=1.
- **Memory address:** `mem_address` is always word-aligned (`{addr[31:2],2'b00}`) whenever a strobe is high. Otherwise it is 0.
- **Lanes (big-endian):** byte offset k maps to bits `[31-8k -: 8]`. Half offset 0 maps to `[31:16]`; half offset 2 maps to `[15:0]`.
- **Load:** at the end of READ, the addressed lane is extracted from `mem_dataOut`, extended, and registered into `rsp_rdata`.
- **Sub-word store:** the word read in READ is registered. The store lane is replaced with the low bits of `req_wdata`. The merged word drives `mem_dataIn` during WRITE.
- **Word store:** `mem_dataIn` = `req_wdata` during WRITE.
- **Strobes:** `mem_readEn` and `mem_writeEn` are never high together. Each is high for exactly one cycle per access.

## Timing
- **Reset:** all outputs 0 and state IDLE, except `req_ready`, which is 1 once `rst` is high.
- **Reset mid-operation:** asynchronous return to IDLE. `mem_writeEn` drops immediately. The response is lost.
- **Latency, accept edge N to `rsp_valid` rising:**
  - load: N+2;
  - word store: N+2;
  - sub-word store: N+3;
  - error: N+1.
- **Write timing:** the memory writes on the falling edge inside the WRITE cycle, so `mem_dataIn` and `mem_address` are stable from the rising edge onward.
- **Back-to-back:** no request is accepted while busy. The response is registered, so the earliest next accept is the edge after `rsp_valid && rsp_ready`.
- **Backpressure:** `rsp_valid`, `rsp_rdata` and `rsp_err` are held stable while `rsp_ready`=0.

## Configuration
- **`MEM_ACCESS_SUBWORD_EN` defined:** byte/half loads and read-modify-write stores as above.
- **`MEM_ACCESS_SUBWORD_EN` undefined:**
  - Any `req_size`≠10 is an error, handled as IDLE→RESP with `rsp_err`=1.
  - The merge/extract logic and the read-data holding register are removed.
  - Word loads and stores are unchanged.

## Structure
- `defines.v` (shared) gains the size encodings `MEM_SZ_BYTE`/`MEM_SZ_HALF`/`MEM_SZ_WORD`. `WORD_LEN` and `DATA_MEM_SIZE` are already shared there.
- State encodings stay local to the module.
- One combinational sub-module, `mem_lane_merge`: lane extract plus extend for loads, and lane merge for stores. It is instantiated only under `MEM_ACCESS_SUBWORD_EN`.

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10 → memory bytes 0x10..0x13 = DE,AD,BE,EF; `rsp_rdata`=0xDEADBEEF; `rsp_valid` 2 cycles after each accept.
- With 0xDEADBEEF @0x10:
  - byte load @0x13 signed → 0xFFFFFFEF;
  - byte load @0x13 unsigned → 0x000000EF;
  - half load @0x10 signed → 0xFFFFDEAD.
- Byte store 0x55 @0x11 over 0xDEADBEEF → word reads 0xDE55BEEF; `rsp_valid` at N+3; exactly one `mem_readEn` pulse and one `mem_writeEn` pulse.
- Word load @0x12, half store @0x11, and word access @`MEM_BYTES-2` → `rsp_err`=1 at N+1; no strobe; memory unchanged.
- Hold `rsp_ready`=0 for 5 cycles → response stable and `req_ready`=0 throughout; accept occurs the cycle after release.
- Pull `rst` low during WRITE → `mem_writeEn` drops immediately and all outputs are 0. Without `MEM_ACCESS_SUBWORD_EN`, a byte load → `rsp_err`=1.
